// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

   localparam int BCD_DIGITS = 5;
   localparam int DIGIT_W    = 4;
   localparam int BCD_W      = BCD_DIGITS * DIGIT_W;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_CONVERT = 1'b1
   } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Binary value in, four BCD digits plus status out.
interface bin2bcd_seq_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] binary;
   logic [3:0]       thousands;
   logic [3:0]       hundreds;
   logic [3:0]       tens;
   logic [3:0]       ones;
   logic             overflow;
   logic             busy;
   logic             done;

   // Producer of the binary value, consumer of the digits.
   modport master (
      output binary,
      input  thousands, hundreds, tens, ones, overflow, busy, done
   );

   // The converter itself.
   modport slave (
      input  binary,
      output thousands, hundreds, tens, ones, overflow, busy, done
   );
endinterface

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit corrector: a digit of 5 or more gets 3 added before the
// shift so that it carries correctly into the next decade.
module bcd_add3
   import bin2bcd_seq_pkg::*;
(
   input  logic [DIGIT_W-1:0] d,
   output logic [DIGIT_W-1:0] q
);

   // Correct digits >= 5; smaller digits pass through.
   always_comb begin
      q = d;
      if (d >= 4'd5) q = d + 4'd3;
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter. Reconverts whenever the binary input
// differs from the last value accepted; digits only change as a full set.
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic          clk,
   input  logic          reset,
   bin2bcd_seq_if.slave  bus
);

   state_t                              state_q, state_d;
   logic [WIDTH-1:0]                    last_q, last_d;
   logic [WIDTH-1:0]                    sh_q, sh_d;
   logic [BCD_W-1:0]                    bcd_q, bcd_d;
   logic [4:0]                          cnt_q, cnt_d;
   logic [DIGIT_W-1:0]                  thousands_q, thousands_d;
   logic [DIGIT_W-1:0]                  hundreds_q, hundreds_d;
   logic [DIGIT_W-1:0]                  tens_q, tens_d;
   logic [DIGIT_W-1:0]                  ones_q, ones_d;
   logic                                overflow_q, overflow_d;
   logic                                busy_q, busy_d;
   logic                                done_q, done_d;

   logic [BCD_DIGITS-1:0][DIGIT_W-1:0]  bcd_adj;
   logic [BCD_W-1:0]                    bcd_shift;

   // One corrector per BCD digit of the accumulator.
   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .d (bcd_q[g*DIGIT_W +: DIGIT_W]),
         .q (bcd_adj[g])
      );
   end

   // Accumulator after this edge's correct-and-shift step.
   assign bcd_shift = {bcd_adj[BCD_DIGITS-1:0]} << 1 | BCD_W'(sh_q[WIDTH-1]);

   // Next-state: capture on change in IDLE, shift/add-3 in CONVERT, publish
   // the complete result on the final shift.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      sh_d        = sh_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      thousands_d = thousands_q;
      hundreds_d  = hundreds_q;
      tens_d      = tens_q;
      ones_d      = ones_q;
      overflow_d  = overflow_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.binary != last_q) begin
               sh_d    = bus.binary;
               last_d  = bus.binary;
               bcd_d   = '0;
               cnt_d   = 5'(WIDTH);
               busy_d  = 1'b1;
               state_d = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            bcd_d = bcd_shift;
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               thousands_d = bcd_shift[15:12];
               hundreds_d  = bcd_shift[11:8];
               tens_d      = bcd_shift[7:4];
               ones_d      = bcd_shift[3:0];
               overflow_d  = (bcd_shift[19:16] != 4'd0);
               done_d      = 1'b1;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All state and registered outputs; reset discards any partial result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         last_q      <= '0;
         sh_q        <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         thousands_q <= '0;
         hundreds_q  <= '0;
         tens_q      <= '0;
         ones_q      <= '0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         sh_q        <= sh_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         thousands_q <= thousands_d;
         hundreds_q  <= hundreds_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         overflow_q  <= overflow_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.thousands = thousands_q;
   assign bus.hundreds  = hundreds_q;
   assign bus.tens      = tens_q;
   assign bus.ones      = ones_q;
   assign bus.overflow  = overflow_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble binary-to-BCD converter between the CPU output port (portc_out, 16-bit binary) and the four-digit seven-segment driver. It replaces the combinational converter on the display path with a 16-cycle shift/add-3 engine. It watches its binary input and reconverts automatically whenever the value changes, holding its previous digits stable until each new result is complete.

## Interface
- WIDTH, 16, binary input width; legal 4..16; BCD engine always 5 digits (20 bits)
- clk  input  1  system clock (mclk domain), rising edge
- reset  input  1  asynchronous, active-high; same net as reset_global
- binary  input  WIDTH  value to display (portc_out)
- thousands  output  4  BCD digit 3
- hundreds  output  4  BCD digit 2
- tens  output  4  BCD digit 1
- ones  output  4  BCD digit 0
- overflow  output  1  converted value > 9999; digit outputs then show the low four BCD digits
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the outputs update

## Operation
- Registers: last[WIDTH-1:0] (last value accepted for conversion), sh[WIDTH-1:0] (binary shift register), bcd[19:0] (5 digits), cnt[4:0], state.
- Reset values: all digit outputs 0, overflow 0, busy 0, done 0, last 0, bcd 0, cnt 0, state IDLE. Outputs already match last = 0, so no conversion runs after reset.
- IDLE: if binary != last on a rising edge, capture binary into sh and last, clear bcd, set cnt = WIDTH, go CONVERT, and assert busy. Otherwise stay in IDLE.
- CONVERT, each edge:
  - Add-3 correct every bcd digit that is >= 5.
  - Shift {bcd, sh} left by one. The MSB of sh enters bcd[0].
  - Decrement cnt.
- On the edge where cnt goes 1 -> 0:
  - Load the post-shift bcd[15:0] into thousands/hundreds/tens/ones.
  - Set overflow = (bcd[19:16] != 0).
  - Pulse done, clear busy, return to IDLE.
- Input changes during CONVERT are ignored. The comparison runs again in IDLE on the next edge, so the most recent value is always eventually displayed.
- Digits are only ever written as a complete, consistent set. No partial result is visible on the outputs.
- Width rule: the input is zero-extended conceptually. 5 BCD digits cover all 16-bit values up to 65535.

## Timing
- Capture edge E0: busy = 1 after E0.
- Conversion edges E1..E_WIDTH (E16 by default). After E16: new digits and overflow are valid, done = 1 for exactly one cycle, busy = 0.
- Latency from capture to valid outputs: WIDTH cycles. With an input that changes every cycle, the minimum spacing between done pulses is WIDTH+1 cycles (IDLE compare cycle plus WIDTH conversion edges).
- If binary changes in the same cycle that done is asserted, it is captured on the next edge. done and busy are never high together.
- Reset asserted mid-conversion: all registers return to reset values immediately (asynchronous). The partial result is discarded and the outputs read 0000. If binary is nonzero after reset release, a new conversion starts on the first edge.
- The outputs are registered. The display driver may sample them on any edge.

## Structure
- Shared header/package constants: ST_IDLE/ST_CONVERT encodings, BCD_DIGITS = 5, DIGIT_W = 4.
- One sub-module, bcd_add3: combinational 4-bit "if >= 5 add 3" corrector, instantiated five times in a generate loop.
- Top-level integration: binary <= portc_out; thousands..ones feed display_7seg_x4 in3..in0; overflow may drive an LED bit.

## Test plan
- Reset: hold reset 2 cycles with binary = 0 -> all digits 0, overflow 0, busy 0, and no done pulse in the following 50 cycles.
- binary = 50 (0x0032) after reset -> busy for 16 cycles, then done pulse, digits 0,0,5,0, overflow 0.
- binary = 9999 -> digits 9,9,9,9, overflow 0. Then binary = 10000 -> digits 0,0,0,0, overflow 1.
- binary = 65535 -> digits 5,5,3,5, overflow 1, done exactly 16 cycles after capture.
- binary changes 123 -> 456 at cycle 5 of a conversion -> first done shows 0,1,2,3. Second conversion starts within 1 cycle of done and finishes with 0,4,5,6. Exactly two done pulses.
- Reset pulsed at cycle 8 of converting 4321 -> outputs 0000 immediately, busy 0. After release, reconversion completes with 4,3,2,1.
